btb_assoc: RTL and testbench

Parametrised set-associative branch target buffer with per-entry 2-bit saturating direction counters, placed in the IF stage next to the PC mux. It answers a fetch-PC lookup in the same cycle with hit, direction and target. It is trained once per resolved branch from EX. A multi-cycle flush sequencer invalidates the whole array on request, for example on a context switch or self-modifying code.

---
 rtl/btb_pkg.sv | 33 +++
 rtl/sat_ctr.sv | 23 ++
 rtl/btb_assoc.sv | 182 ++++++++++++++++++
 tb/tb_btb_assoc.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
package btb_pkg;

  // Flush sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } flushState_t;

  // Weakly-taken value for the default 2-bit direction counter
  localparam logic [1:0] CNT_INIT = 2'b10;

  // Weakly-taken value for a counter of arbitrary width: MSB set, rest clear
  function automatic int cntInitVal(input int cntW);
    return 1 << (cntW - 1);
  endfunction

  // Number of PC bits used as the set index
  function automatic int idxBits(input int sets);
    return $clog2(sets);
  endfunction

  // Number of PC bits stored as the tag (everything above index and byte offset)
  function automatic int tagBits(input int addrW, input int sets);
    return addrW - 2 - $clog2(sets);
  endfunction

  // Width of a way number / round-robin pointer, never below 1 bit
  function automatic int wayBits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/sat_ctr.sv
// Saturating up/down counter next-state logic, shared by the BTB and the BHT.
module sat_ctr #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cntNext
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Step one toward the requested direction, holding at either rail
  always_comb begin
    cntNext = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) begin
      cntNext = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cntNext = cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with 2-bit direction counters and a
// one-set-per-cycle flush sweep.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | lookups and EX training active
//   SWEEP | clearing set sweepIdx; lookups forced to miss, updates dropped
module btb_assoc
  import btb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              flush_req,
  output logic              flush_busy
);

  localparam int IDX_W = idxBits(SETS);
  localparam int TAG_W = tagBits(ADDR_W, SETS);
  localparam int WAY_W = wayBits(WAYS);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(cntInitVal(CNT_W));
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

  logic              validArr  [SETS][WAYS];
  logic [TAG_W-1:0]  tagArr    [SETS][WAYS];
  logic [ADDR_W-1:0] targetArr [SETS][WAYS];
  logic [CNT_W-1:0]  cntArr    [SETS][WAYS];
  logic [WAY_W-1:0]  rrArr     [SETS];

  flushState_t      state;
  logic [IDX_W-1:0] sweepIdx;
  logic             busy;

  logic [IDX_W-1:0] fIdx, uIdx;
  logic [TAG_W-1:0] fTag, uTag;
  logic             lkHit, updHit, anyInvalid, updEn;
  logic [WAY_W-1:0] lkWay, updWay, invWay, victim, wrWay, rrNext;
  logic [CNT_W-1:0] cntNext;
  logic [3:0]       unusedPcLsbs;

  assign fIdx = fetch_pc[2 +: IDX_W];
  assign fTag = fetch_pc[ADDR_W-1 -: TAG_W];
  assign uIdx = upd_pc[2 +: IDX_W];
  assign uTag = upd_pc[ADDR_W-1 -: TAG_W];
  assign unusedPcLsbs = {fetch_pc[1:0], upd_pc[1:0]};

  // Fetch-side tag match; scanning downward lets the lowest way win
  always_comb begin
    lkHit = 1'b0;
    lkWay = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (validArr[fIdx][w] && (tagArr[fIdx][w] == fTag)) begin
        lkHit = 1'b1;
        lkWay = WAY_W'(w);
      end
    end
  end

  // Prediction outputs, suppressed during reset and while sweeping
  always_comb begin
    hit         = lkHit && !busy && !rst;
    pred_taken  = hit && cntArr[fIdx][lkWay][CNT_W-1];
    pred_target = hit ? targetArr[fIdx][lkWay] : '0;
  end

  // Update-side tag match plus victim choice (lowest invalid way, else rr)
  always_comb begin
    updHit     = 1'b0;
    updWay     = '0;
    anyInvalid = 1'b0;
    invWay     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (validArr[uIdx][w] && (tagArr[uIdx][w] == uTag)) begin
        updHit = 1'b1;
        updWay = WAY_W'(w);
      end
      if (!validArr[uIdx][w]) begin
        anyInvalid = 1'b1;
        invWay     = WAY_W'(w);
      end
    end
    victim = anyInvalid ? invWay : rrArr[uIdx];
    wrWay  = updHit ? updWay : victim;
    rrNext = (rrArr[uIdx] == LAST_WAY) ? '0 : rrArr[uIdx] + WAY_W'(1);
  end

  // Training is only accepted in IDLE, and a simultaneous flush takes priority
  assign updEn = upd_valid && (state == IDLE) && !flush_req;

  sat_ctr #(.CNT_W(CNT_W)) uDirCtr (
    .cnt     (cntArr[uIdx][updWay]),
    .inc     (upd_taken),
    .dec     (!upd_taken),
    .cntNext (cntNext)
  );

  // Flush sequencer: walk every set once, then return to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sweepIdx <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_req) begin
            state    <= SWEEP;
            sweepIdx <= '0;
            busy     <= 1'b1;
          end
        end
        SWEEP: begin
          if (sweepIdx == LAST_SET) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sweepIdx <= sweepIdx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign flush_busy = busy;

  // Valid bits, counters and victim pointers: reset, sweep or train
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          validArr[s][w] <= 1'b0;
          cntArr[s][w]   <= '0;
        end
        rrArr[s] <= '0;
      end
    end else if (state == SWEEP) begin
      for (int w = 0; w < WAYS; w++) begin
        validArr[sweepIdx][w] <= 1'b0;
        cntArr[sweepIdx][w]   <= '0;
      end
      rrArr[sweepIdx] <= '0;
    end else if (updEn) begin
      if (updHit) begin
        cntArr[uIdx][updWay] <= cntNext;
      end else if (upd_taken) begin
        validArr[uIdx][victim] <= 1'b1;
        cntArr[uIdx][victim]   <= CNT_START;
        if (!anyInvalid) begin
          rrArr[uIdx] <= rrNext;
        end
      end
    end
  end

  // Tag and target payload; not reset because valid gates every use
  always_ff @(posedge clk) begin
    if (!rst && updEn && upd_taken) begin
      targetArr[uIdx][wrWay] <= upd_target;
      if (!updHit) begin
        tagArr[uIdx][wrWay] <= uTag;
      end
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed scoreboard bench for btb_assoc at default parameters.
module tb_btb_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        hit, pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush_req;
  logic        flush_busy;

  btb_assoc dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_pc    (fetch_pc),
    .hit         (hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic        busy;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  logic  chkReq;
  int    checks = 0;
  int    passed = 0;
  exp_t  e;
  exp_t  got;
  string nm;

  // Monitor: whenever a lookup is presented, pop its expectation and compare
  always @(negedge clk) begin
    if (chkReq) begin
      got = '{hit, pred_taken, pred_target, flush_busy};
      checks++;
      if (expQ.size() == 0) begin
        $display("FAIL scoreboard_underflow: lookup presented with no expected value queued");
      end else begin
        e  = expQ.pop_front();
        nm = nameQ.pop_front();
        if (got !== e)
          $display("FAIL %s: got hit=%0b taken=%0b target=%h busy=%0b, expected hit=%0b taken=%0b target=%h busy=%0b",
                   nm, got.hit, got.taken, got.tgt, got.busy, e.hit, e.taken, e.tgt, e.busy);
        else
          passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    flush_req = 1'b0;
    chkReq    = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc, input logic h, input logic t,
                      input logic [31:0] tg, input logic b, input string name);
    fetch_pc = pc;
    chkReq   = 1'b1;
    expQ.push_back(exp_t'{h, t, tg, b});
    nameQ.push_back(name);
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tg;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_pc = 32'h40; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; flush_req = 1'b0; chkReq = 1'b0;
    tick();
    look(32'h40, 0, 0, 32'h0, 0, "during_reset"); tick();
    rst = 1'b0;
    look(32'h40, 0, 0, 32'h0, 0, "after_reset_miss"); tick();

    // Allocate, then train down; lookup in the update cycle sees old contents
    upd(32'h100, 1, 32'h200);
    look(32'h100, 0, 0, 32'h0, 0, "alloc_same_cycle"); tick();
    look(32'h100, 1, 1, 32'h200, 0, "alloc_next_cycle");
    upd(32'h100, 0, 32'hBAD); tick();
    look(32'h100, 1, 0, 32'h200, 0, "not_taken_1");
    upd(32'h100, 0, 32'hBAD); tick();
    look(32'h100, 1, 0, 32'h200, 0, "not_taken_2_target_kept"); tick();

    // Set 0 eviction: invalid way first, then round-robin
    upd(32'h500, 1, 32'h5A0); tick();
    upd(32'h900, 1, 32'h9A0); tick();
    look(32'h100, 0, 0, 32'h0, 0, "evict_way0"); tick();
    look(32'h500, 1, 1, 32'h5A0, 0, "way1_kept"); tick();
    look(32'h900, 1, 1, 32'h9A0, 0, "new_in_way0"); tick();
    upd(32'hD00, 1, 32'hDA0); tick();
    look(32'h500, 0, 0, 32'h0, 0, "rr_evict_way1"); tick();
    look(32'hD00, 1, 1, 32'hDA0, 0, "rr_new_entry"); tick();
    look(32'h900, 1, 1, 32'h9A0, 0, "rr_other_kept"); tick();

    // Counter saturation at both rails (set 1)
    upd(32'h104, 1, 32'h310); tick();
    upd(32'h104, 1, 32'h320); tick();
    upd(32'h104, 1, 32'h330); tick();
    upd(32'h104, 1, 32'h340); tick();
    look(32'h104, 1, 1, 32'h340, 0, "sat_high_target_updated");
    upd(32'h104, 0, 32'hBAD); tick();
    look(32'h104, 1, 1, 32'h340, 0, "sat_high_one_down"); tick();
    for (int i = 0; i < 4; i++) begin
      upd(32'h104, 0, 32'hBAD); tick();
    end
    look(32'h104, 1, 0, 32'h340, 0, "sat_low_no_wrap");
    upd(32'h104, 1, 32'h350); tick();
    look(32'h104, 1, 0, 32'h350, 0, "sat_low_one_up"); tick();

    // Full flush: exactly 16 busy cycles, updates and repeat requests ignored
    upd(32'h108, 1, 32'h380); tick();
    look(32'h900, 1, 1, 32'h9A0, 0, "pre_flush");
    flush_req = 1'b1; tick();
    for (int i = 1; i <= 16; i++) begin
      look(32'h900, 0, 0, 32'h0, 1, "sweep_busy");
      if (i == 3)  upd(32'h180, 1, 32'h111);
      if (i == 5)  flush_req = 1'b1;
      if (i == 16) upd(32'h140, 1, 32'h222);
      tick();
    end
    look(32'h900, 0, 0, 32'h0, 0, "sweep_done"); tick();
    look(32'h104, 0, 0, 32'h0, 0, "flushed_set1"); tick();
    look(32'h108, 0, 0, 32'h0, 0, "flushed_set2"); tick();
    look(32'h180, 0, 0, 32'h0, 0, "upd_dropped_mid_sweep"); tick();
    look(32'h140, 0, 0, 32'h0, 0, "upd_dropped_last_sweep"); tick();

    // Reset in the middle of a sweep (set 15 entry not yet reached)
    upd(32'h33C, 1, 32'h3A0);
    look(32'h33C, 0, 0, 32'h0, 0, "same_set_same_cycle"); tick();
    look(32'h33C, 1, 1, 32'h3A0, 0, "same_set_next_cycle");
    flush_req = 1'b1; tick();
    for (int i = 1; i <= 5; i++) begin
      look(32'h33C, 0, 0, 32'h0, 1, "sweep2_busy");
      if (i == 5) rst = 1'b1;
      tick();
    end
    rst = 1'b0;
    look(32'h33C, 0, 0, 32'h0, 0, "rst_mid_sweep_cleared"); tick();
    upd(32'h33C, 1, 32'h3B0); tick();
    look(32'h33C, 1, 1, 32'h3B0, 0, "train_after_rst"); tick();

    tick();
    if (expQ.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
